ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/arc_pkg.sv | 53 +++++
 rtl/ctrl_hazard.sv | 38 +++
 rtl/ctrl_pipe.sv | 110 +++++++++++
 tb/tb_ctrl_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc_pkg.sv
// Shared control-pipeline types and encodings.
// Stage bundles split the decoded controls by the stage that consumes them.
package arc_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [3:0] OTHER_ANDI = 4'b0001;
    localparam logic [3:0] OTHER_ORI  = 4'b0010;
    localparam logic [3:0] OTHER_XORI = 4'b0011;
    localparam logic [3:0] OTHER_BEQ  = 4'b0100;
    localparam logic [3:0] OTHER_BNE  = 4'b0101;

    typedef struct packed {
        logic [1:0] aluop;
        logic [3:0] other;
        logic       alusrc;
        logic       branch;
    } ex_ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    typedef struct packed {
        logic       valid;
        ex_ctrl_t   ex;
        mem_ctrl_t  mem;
        wb_ctrl_t   wb;
        logic [4:0] dst;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        mem_ctrl_t  mem;
        wb_ctrl_t   wb;
        logic [4:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        wb_ctrl_t   wb;
        logic [4:0] dst;
    } mem_wb_t;

endpackage

// File: rtl/ctrl_hazard.sv
// Branch resolution and load-use detection for the instruction in EX.
// A taken branch squashes ID, so it suppresses any stall request.
module ctrl_hazard
    import arc_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_branch,
    input  logic [3:0] i_ex_other,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_dst,
    input  logic       i_zero,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_pcsrc,
    output logic       o_stall
);

    logic br_cond;
    logic use_hit;

    always_comb begin
        br_cond = 1'b0;
        unique case (i_ex_other)
            OTHER_BEQ: br_cond = i_zero;
            OTHER_BNE: br_cond = ~i_zero;
            default:   br_cond = 1'b0;
        endcase
    end

    assign o_pcsrc = i_ex_valid & i_ex_branch & br_cond;

    assign use_hit = (i_ex_dst == i_id_rs) | (i_ex_dst == i_id_rt);

    assign o_stall = i_ex_valid & i_ex_memread & (i_ex_dst != 5'd0)
                   & i_id_valid & use_hit & ~o_pcsrc;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline: ID/EX, EX/MEM, MEM/WB registers
// with hold, branch squash and load-use bubble insertion.
module ctrl_pipe
    import arc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cp_hold,
    input  logic       i_cp_valid,
    input  logic       i_cp_regdst,
    input  logic       i_cp_branch,
    input  logic       i_cp_memread,
    input  logic       i_cp_memtoreg,
    input  logic       i_cp_memwrite,
    input  logic       i_cp_alusrc,
    input  logic       i_cp_regwrite,
    input  logic [1:0] i_cp_aluop,
    input  logic [3:0] i_cp_other,
    input  logic [4:0] i_cp_rs,
    input  logic [4:0] i_cp_rt,
    input  logic [4:0] i_cp_rd,
    input  logic       i_cp_zero,
    output logic [1:0] o_cp_ex_aluop,
    output logic [3:0] o_cp_ex_other,
    output logic       o_cp_ex_alusrc,
    output logic       o_cp_mem_memread,
    output logic       o_cp_mem_memwrite,
    output logic       o_cp_wb_regwrite,
    output logic       o_cp_wb_memtoreg,
    output logic [4:0] o_cp_wb_dst,
    output logic       o_cp_pcsrc,
    output logic       o_cp_stall
);

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;
    id_ex_t  id_cap;

    ctrl_hazard u_hazard (
        .i_ex_valid   (id_ex_q.valid),
        .i_ex_branch  (id_ex_q.ex.branch),
        .i_ex_other   (id_ex_q.ex.other),
        .i_ex_memread (id_ex_q.mem.memread),
        .i_ex_dst     (id_ex_q.dst),
        .i_zero       (i_cp_zero),
        .i_id_valid   (i_cp_valid),
        .i_id_rs      (i_cp_rs),
        .i_id_rt      (i_cp_rt),
        .o_pcsrc      (o_cp_pcsrc),
        .o_stall      (o_cp_stall)
    );

    always_comb begin
        id_cap              = '0;
        id_cap.valid        = 1'b1;
        id_cap.ex.aluop     = i_cp_aluop;
        id_cap.ex.other     = i_cp_other;
        id_cap.ex.alusrc    = i_cp_alusrc;
        id_cap.ex.branch    = i_cp_branch;
        id_cap.mem.memread  = i_cp_memread;
        id_cap.mem.memwrite = i_cp_memwrite;
        id_cap.wb.regwrite  = i_cp_regwrite;
        id_cap.wb.memtoreg  = i_cp_memtoreg;
        id_cap.dst          = i_cp_regdst ? i_cp_rd : i_cp_rt;
    end

    // Hold keeps every stage; otherwise downstream always advances.
    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (!i_cp_hold) begin
            mem_wb_d.valid = ex_mem_q.valid;
            mem_wb_d.wb    = ex_mem_q.wb;
            mem_wb_d.dst   = ex_mem_q.dst;
            ex_mem_d.valid = id_ex_q.valid;
            ex_mem_d.mem   = id_ex_q.mem;
            ex_mem_d.wb    = id_ex_q.wb;
            ex_mem_d.dst   = id_ex_q.dst;
            if (o_cp_pcsrc || o_cp_stall || !i_cp_valid) begin
                id_ex_d = '0;
            end else begin
                id_ex_d = id_cap;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign o_cp_ex_aluop     = id_ex_q.ex.aluop & {2{id_ex_q.valid}};
    assign o_cp_ex_other     = id_ex_q.ex.other & {4{id_ex_q.valid}};
    assign o_cp_ex_alusrc    = id_ex_q.ex.alusrc & id_ex_q.valid;
    assign o_cp_mem_memread  = ex_mem_q.mem.memread & ex_mem_q.valid;
    assign o_cp_mem_memwrite = ex_mem_q.mem.memwrite & ex_mem_q.valid;
    assign o_cp_wb_regwrite  = mem_wb_q.wb.regwrite & mem_wb_q.valid;
    assign o_cp_wb_memtoreg  = mem_wb_q.wb.memtoreg & mem_wb_q.valid;
    assign o_cp_wb_dst       = mem_wb_q.dst & {5{mem_wb_q.valid}};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized and directed checks of ctrl_pipe against an
// instruction-level model of a three-slot control pipeline.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic [3:0] other;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic       v;
    logic       regdst, branch, memread, memtoreg;
    logic       memwrite, alusrc, regwrite;
    logic [1:0] aluop;
    logic [3:0] other;
    logic [4:0] rs, rt, rd;
    logic       zero;
    logic [1:0] ex_aluop;
    logic [3:0] ex_other;
    logic       ex_alusrc;
    logic       mem_memread, mem_memwrite;
    logic       wb_regwrite, wb_memtoreg;
    logic [4:0] wb_dst;
    logic       pcsrc, stall;

    ctrl_pipe dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cp_hold         (hold),
        .i_cp_valid        (v),
        .i_cp_regdst       (regdst),
        .i_cp_branch       (branch),
        .i_cp_memread      (memread),
        .i_cp_memtoreg     (memtoreg),
        .i_cp_memwrite     (memwrite),
        .i_cp_alusrc       (alusrc),
        .i_cp_regwrite     (regwrite),
        .i_cp_aluop        (aluop),
        .i_cp_other        (other),
        .i_cp_rs           (rs),
        .i_cp_rt           (rt),
        .i_cp_rd           (rd),
        .i_cp_zero         (zero),
        .o_cp_ex_aluop     (ex_aluop),
        .o_cp_ex_other     (ex_other),
        .o_cp_ex_alusrc    (ex_alusrc),
        .o_cp_mem_memread  (mem_memread),
        .o_cp_mem_memwrite (mem_memwrite),
        .o_cp_wb_regwrite  (wb_regwrite),
        .o_cp_wb_memtoreg  (wb_memtoreg),
        .o_cp_wb_dst       (wb_dst),
        .o_cp_pcsrc        (pcsrc),
        .o_cp_stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // model: slot 0 = EX, 1 = MEM, 2 = WB
    instr_t m_s [3];
    instr_t cur;
    logic   cur_hold, cur_zero, cur_rst;
    logic   exp_pc, exp_st;

    function automatic logic [4:0] dst_of(instr_t x);
        return x.regdst ? x.rd : x.rt;
    endfunction

    function automatic instr_t nop();
        instr_t x = '0;
        return x;
    endfunction

    function automatic instr_t rtype(logic [4:0] s, logic [4:0] t, logic [4:0] d);
        instr_t x = '0;
        x.valid = 1; x.regdst = 1; x.regwrite = 1; x.aluop = 2'b10;
        x.rs = s; x.rt = t; x.rd = d;
        return x;
    endfunction

    function automatic instr_t itype(logic [1:0] op, logic [3:0] o,
                                     logic [4:0] s, logic [4:0] t);
        instr_t x = '0;
        x.valid = 1; x.alusrc = 1; x.regwrite = 1; x.aluop = op;
        x.other = o; x.rs = s; x.rt = t; x.rd = 5'd31;
        return x;
    endfunction

    function automatic instr_t lw(logic [4:0] s, logic [4:0] t);
        instr_t x = itype(2'b00, 4'd0, s, t);
        x.memread = 1; x.memtoreg = 1;
        return x;
    endfunction

    function automatic instr_t br(logic [3:0] o, logic [4:0] s, logic [4:0] t);
        instr_t x = '0;
        x.valid = 1; x.branch = 1; x.aluop = 2'b11; x.other = o;
        x.rs = s; x.rt = t;
        return x;
    endfunction

    function automatic instr_t rnd();
        instr_t x;
        x = $urandom;
        x.valid = ($urandom_range(0, 5) != 0);
        x.other = 4'($urandom_range(0, 6));
        x.rs = 5'($urandom_range(0, 7));
        x.rt = 5'($urandom_range(0, 7));
        x.rd = 5'($urandom_range(0, 7));
        return x;
    endfunction

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        instr_t e = m_s[0];
        instr_t m = m_s[1];
        instr_t w = m_s[2];
        logic [4:0] ed = dst_of(e);
        exp_pc = e.valid && e.branch &&
                 ((e.other == 4'b0100 && cur_zero) || (e.other == 4'b0101 && !cur_zero));
        exp_st = !exp_pc && e.valid && e.memread && ed != 0 && cur.valid &&
                 (ed == cur.rs || ed == cur.rt);
        lit("ex_aluop", 32'(ex_aluop), e.valid ? 32'(e.aluop) : 0);
        lit("ex_other", 32'(ex_other), e.valid ? 32'(e.other) : 0);
        lit("ex_alusrc", 32'(ex_alusrc), 32'(e.valid & e.alusrc));
        lit("mem_memread", 32'(mem_memread), 32'(m.valid & m.memread));
        lit("mem_memwrite", 32'(mem_memwrite), 32'(m.valid & m.memwrite));
        lit("wb_regwrite", 32'(wb_regwrite), 32'(w.valid & w.regwrite));
        lit("wb_memtoreg", 32'(wb_memtoreg), 32'(w.valid & w.memtoreg));
        lit("wb_dst", 32'(wb_dst), w.valid ? 32'(dst_of(w)) : 0);
        lit("pcsrc", 32'(pcsrc), 32'(exp_pc));
        lit("stall", 32'(stall), 32'(exp_st));
    endtask

    task automatic cyc(input instr_t x, input logic h = 0,
                       input logic z = 0, input logic r = 1);
        @(negedge clk);
        cur = x; cur_hold = h; cur_zero = z; cur_rst = r;
        rst_n = r; hold = h; zero = z; v = x.valid;
        regdst = x.regdst; branch = x.branch; memread = x.memread;
        memtoreg = x.memtoreg; memwrite = x.memwrite; alusrc = x.alusrc;
        regwrite = x.regwrite; aluop = x.aluop; other = x.other;
        rs = x.rs; rt = x.rt; rd = x.rd;
        #1;
        chk_model();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!cur_rst) begin
            for (int i = 0; i < 3; i++) m_s[i] = '0;
        end else if (!cur_hold) begin
            m_s[2] = m_s[1];
            m_s[1] = m_s[0];
            m_s[0] = (exp_pc || exp_st || !cur.valid) ? nop() : cur;
        end
    endtask

    initial begin
        cur = nop();
        for (int i = 0; i < 3; i++) m_s[i] = '0;
        rst_n = 0; hold = 0; zero = 0; v = 0;
        regdst = 0; branch = 0; memread = 0; memtoreg = 0; memwrite = 0;
        alusrc = 0; regwrite = 0; aluop = 0; other = 0; rs = 0; rt = 0; rd = 0;
        repeat (2) @(posedge clk);

        // reset state, then reset mid-stream after three ADDIs
        cyc(nop(), 0, 0, 0);
        lit("rst_wb_dst", 32'(wb_dst), 0);
        adv();
        cyc(itype(2'b00, 4'd0, 5'd1, 5'd2)); adv();
        cyc(itype(2'b00, 4'd0, 5'd1, 5'd3)); adv();
        cyc(itype(2'b00, 4'd0, 5'd1, 5'd4));
        lit("pre_rst_wb_regwrite", 32'(wb_regwrite), 0);
        adv();
        cyc(nop(), 0, 0, 0); adv();
        for (int k = 0; k < 3; k++) begin
            cyc(nop());
            lit("post_rst_wb_regwrite", 32'(wb_regwrite), 0);
            lit("post_rst_ex_aluop", 32'(ex_aluop), 0);
            adv();
        end

        // ORI into r9: EX at +1, WB at +3
        cyc(itype(2'b11, 4'b0010, 5'd1, 5'd9)); adv();
        cyc(nop());
        lit("ori_ex_other", 32'(ex_other), 32'h2);
        lit("ori_ex_alusrc", 32'(ex_alusrc), 1);
        adv();
        cyc(nop()); adv();
        cyc(nop());
        lit("ori_wb_dst", 32'(wb_dst), 9);
        lit("ori_wb_regwrite", 32'(wb_regwrite), 1);
        adv();

        // load-use on r5, then r0 never stalls
        cyc(lw(5'd1, 5'd5)); adv();
        cyc(rtype(5'd5, 5'd2, 5'd3));
        lit("lu_stall", 32'(stall), 1);
        adv();
        cyc(rtype(5'd5, 5'd2, 5'd3));
        lit("lu_stall_clear", 32'(stall), 0);
        lit("lu_bubble", 32'(ex_aluop), 0);
        adv();
        cyc(nop());
        lit("lu_add_in_ex", 32'(ex_aluop), 32'h2);
        adv();
        cyc(lw(5'd1, 5'd0)); adv();
        cyc(rtype(5'd0, 5'd0, 5'd3));
        lit("lu_r0_stall", 32'(stall), 0);
        adv();

        // BEQ taken squashes ID; not taken lets it through
        cyc(br(4'b0100, 5'd1, 5'd2)); adv();
        cyc(rtype(5'd1, 5'd2, 5'd3), 0, 1);
        lit("beq_pcsrc", 32'(pcsrc), 1);
        adv();
        cyc(nop());
        lit("beq_squash", 32'(ex_aluop), 0);
        adv();
        cyc(br(4'b0100, 5'd1, 5'd2)); adv();
        cyc(rtype(5'd1, 5'd2, 5'd3), 0, 0);
        lit("beq_nt_pcsrc", 32'(pcsrc), 0);
        adv();
        cyc(nop());
        lit("beq_nt_ex", 32'(ex_aluop), 32'h2);
        adv();

        // BNE taken while ID would otherwise be a load-use consumer
        cur = br(4'b0101, 5'd1, 5'd7);
        cur.memread = 1;
        cyc(cur); adv();
        cyc(rtype(5'd7, 5'd2, 5'd3), 0, 0);
        lit("bne_pcsrc", 32'(pcsrc), 1);
        lit("bne_stall", 32'(stall), 0);
        adv();
        cyc(nop());
        lit("bne_bubble", 32'(ex_aluop), 0);
        adv();

        // hold with a full pipe
        cyc(itype(2'b11, 4'b0011, 5'd0, 5'd4)); adv();
        cyc(itype(2'b11, 4'b0001, 5'd0, 5'd6)); adv();
        cyc(itype(2'b11, 4'b0010, 5'd0, 5'd8)); adv();
        for (int k = 0; k < 3; k++) begin
            cyc(rtype(5'd1, 5'd2, 5'd3), 1);
            lit("hold_wb_dst", 32'(wb_dst), 4);
            lit("hold_ex_other", 32'(ex_other), 32'h2);
            adv();
        end
        cyc(nop()); adv();
        cyc(nop()); adv();
        cyc(nop());
        lit("hold_resume_wb", 32'(wb_dst), 8);
        adv();

        // randomized traffic; ID is re-presented on hold or stall
        cur = rnd();
        for (int n = 0; n < 3000; n++) begin
            cyc(cur, ($urandom_range(0, 7) == 0), 1'($urandom),
                ($urandom_range(0, 63) != 0));
            adv();
            if (!cur_rst || !(cur_hold || exp_st)) cur = rnd();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
